// File: rtl/fetch_pkg.sv
// Shared defaults and helpers for the instruction-fetch front end.
package fetch_pkg;

  localparam int FETCH_XLEN    = 32;
  localparam int FETCH_DEPTH   = 4;
  localparam int FETCH_PC_STEP = 1;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [31:0]           inst;
    logic                  filled;
  } fetch_entry_t;

  // One extra MSB distinguishes full from empty when the index bits match.
  function automatic int fetch_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_ring_buf.sv
// In-order ring of fetch slots: allocated at request, filled at response, drained by decode.
module fetch_ring_buf
  import fetch_pkg::*;
#(
  parameter int XLEN  = FETCH_XLEN,
  parameter int DEPTH = FETCH_DEPTH,
  parameter int PW    = fetch_ptr_w(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            alloc_en,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic            fill_en,
  input  logic [31:0]     fill_inst,
  input  logic            rd_en,
  output logic            rd_valid,
  output logic [XLEN-1:0] rd_pc,
  output logic [31:0]     rd_inst,
  output logic            full,
  output logic [PW-1:0]   pending
);

  localparam int IW = PW - 1;

  logic [XLEN-1:0]  pc_mem   [DEPTH];
  logic [31:0]      inst_mem [DEPTH];
  logic [DEPTH-1:0] filled, filled_nxt;
  logic [PW-1:0]    alloc_ptr, fill_ptr, rd_ptr;
  logic [IW-1:0]    alloc_idx, fill_idx, rd_idx;

  assign alloc_idx = alloc_ptr[IW-1:0];
  assign fill_idx  = fill_ptr[IW-1:0];
  assign rd_idx    = rd_ptr[IW-1:0];

  always_comb begin
    filled_nxt = filled;
    if (rd_en)    filled_nxt[rd_idx]    = 1'b0;
    if (alloc_en) filled_nxt[alloc_idx] = 1'b0;
    if (fill_en)  filled_nxt[fill_idx]  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      filled    <= '0;
    end else if (flush) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      filled    <= '0;
    end else begin
      if (alloc_en) alloc_ptr <= alloc_ptr + PW'(1);
      if (fill_en)  fill_ptr  <= fill_ptr + PW'(1);
      if (rd_en)    rd_ptr    <= rd_ptr + PW'(1);
      filled <= filled_nxt;
    end
  end

  // Payload needs no reset: outputs are masked by the filled bit.
  always_ff @(posedge clk) begin
    if (alloc_en) pc_mem[alloc_idx]  <= alloc_pc;
    if (fill_en)  inst_mem[fill_idx] <= fill_inst;
  end

  assign rd_valid = filled[rd_idx];
  assign rd_pc    = rd_valid ? pc_mem[rd_idx] : '0;
  assign rd_inst  = rd_valid ? inst_mem[rd_idx] : '0;
  assign full     = (alloc_ptr[IW] != rd_ptr[IW]) && (alloc_idx == rd_idx);
  assign pending  = alloc_ptr - fill_ptr;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Prefetching IF stage: owns the PC, issues imem requests, drops wrong-path responses after redirect.
// Define FETCH_PERF_CNT_EN to add the redirect and stall performance counters.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = FETCH_XLEN,
  parameter int              DEPTH    = FETCH_DEPTH,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = FETCH_PC_STEP
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_inst,
  input  logic            id_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_redirect_cnt,
  output logic [31:0]     perf_stall_cnt
`endif
);

  localparam int PW = fetch_ptr_w(DEPTH);
  // Headroom for wrong-path residue accumulated over back-to-back redirects.
  localparam int DW = PW + 2;

  logic [XLEN-1:0] fetch_pc;
  logic [DW-1:0]   drop_cnt, drop_nxt, in_flight;
  logic [PW-1:0]   pending;
  logic            full, rd_valid, id_fire, req_ok, req_fire, fill_en;

  assign id_fire  = rd_valid & id_ready;
  assign req_ok   = rst_n & ~stall & ~redirect_valid & (~full | id_fire);
  assign req_fire = req_ok & imem_req_ready;
  assign fill_en  = imem_rsp_valid & ~redirect_valid & (drop_cnt == '0) & (pending != '0);

  assign imem_req_valid = req_ok;
  assign imem_req_addr  = req_ok ? fetch_pc : '0;
  assign id_valid       = rd_valid;

  assign in_flight = drop_cnt + DW'(pending);

  always_comb begin
    drop_nxt = drop_cnt;
    if (redirect_valid)
      drop_nxt = in_flight - DW'(imem_rsp_valid && (in_flight != '0));
    else if (imem_rsp_valid && (drop_cnt != '0))
      drop_nxt = drop_cnt - DW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
    end else begin
      drop_cnt <= drop_nxt;
      if (redirect_valid)
        fetch_pc <= redirect_pc;
      else if (req_fire)
        fetch_pc <= fetch_pc + XLEN'(PC_STEP);
    end
  end

  fetch_ring_buf #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_ring (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .alloc_en  (req_fire),
    .alloc_pc  (fetch_pc),
    .fill_en   (fill_en),
    .fill_inst (imem_rsp_data),
    .rd_en     (id_fire),
    .rd_valid  (rd_valid),
    .rd_pc     (id_pc),
    .rd_inst   (id_inst),
    .full      (full),
    .pending   (pending)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_redirect_cnt <= '0;
      perf_stall_cnt    <= '0;
    end else begin
      if (redirect_valid)
        perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
      if (stall || (full && !id_fire))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: per-cycle vector table plus redirect/stall/reset sequences.
module tb_fetch_prefetch_unit;

  logic        clk = 1'b0;
  logic        rst_n, stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        id_valid, id_ready;
  logic [31:0] id_pc, id_inst;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_redirect_cnt, perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  fetch_prefetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_inst        (id_inst),
    .id_ready       (id_ready)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_redirect_cnt (perf_redirect_cnt),
    .perf_stall_cnt    (perf_stall_cnt)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int lat = 1;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          req;
    logic [31:0] addr;
    bit          idv;
    logic [31:0] pc;
  } vec_t;

  mreq_t       mq[$];
  logic [31:0] dq[$];
  vec_t        vecs[$];

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_dq(input string name, input int idx, input logic [31:0] exp);
    if (dq.size() > idx) begin
      check(name, dq[idx], exp);
    end else begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: delivery %0d never arrived, expected pc %h", name, idx, exp);
    end
  endtask

  // Memory acceptance and decode-side delivery are observed mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_req_valid && imem_req_ready)
        mq.push_back('{imem_req_addr, cyc + lat});
      if (id_valid && id_ready) begin
        dq.push_back(id_pc);
        check("delivered inst", id_inst, inst_of(id_pc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = inst_of(mq[0].addr);
      void'(mq.pop_front());
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    mq.delete();
    dq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic drive(input logic st, input logic rv, input logic [31:0] rp, input logic rdy);
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rp;
    imem_req_ready = rdy;
    @(negedge clk);
  endtask

  task automatic run(input logic st, input logic rv, input logic [31:0] rp, input logic rdy);
    step();
    drive(st, rv, rp, rdy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    id_ready       = 1'b0;

    // Streaming with decode always ready: one instruction per cycle from cycle 2.
    vecs.push_back('{1'b1, 1'b1, 1'b1, 32'd0, 1'b0, 32'd0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 32'd1, 1'b0, 32'd0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 32'd2, 1'b1, 32'd0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 32'd3, 1'b1, 32'd1});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 32'd4, 1'b1, 32'd2});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 32'd5, 1'b1, 32'd3});
    // Decode blocked 10 cycles: four requests fill the ring, pc 0 held, then release.
    vecs.push_back('{1'b1, 1'b0, 1'b1, 32'd0, 1'b0, 32'd0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 32'd1, 1'b0, 32'd0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 32'd2, 1'b1, 32'd0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 32'd3, 1'b1, 32'd0});
    for (int i = 0; i < 6; i++)
      vecs.push_back('{1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0});
    for (int i = 0; i < 6; i++)
      vecs.push_back('{1'b0, 1'b1, 1'b1, 32'(4 + i), 1'b1, 32'(i)});

    lat = 1;
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      else             step();
      id_ready = vecs[i].rdy;
      drive(1'b0, 1'b0, 32'd0, 1'b1);
      check($sformatf("vec%0d req_valid", i), {31'b0, imem_req_valid}, {31'b0, vecs[i].req});
      check($sformatf("vec%0d req_addr", i), imem_req_addr, vecs[i].addr);
      check($sformatf("vec%0d id_valid", i), {31'b0, id_valid}, {31'b0, vecs[i].idv});
      check($sformatf("vec%0d id_pc", i), id_pc, vecs[i].pc);
      check($sformatf("vec%0d id_inst", i), id_inst, vecs[i].idv ? inst_of(vecs[i].pc) : 32'd0);
    end

    // Redirect to 0x40 with two responses outstanding on 3-cycle memory.
    lat = 3;
    id_ready = 1'b1;
    do_reset();
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    run(1'b0, 1'b0, 32'd0, 1'b1);
    run(1'b0, 1'b1, 32'h40, 1'b1);
    check("t3 no req on redirect", {31'b0, imem_req_valid}, 32'd0);
    run(1'b0, 1'b0, 32'd0, 1'b1);
    check("t3 req_valid after redirect", {31'b0, imem_req_valid}, 32'd1);
    check("t3 req_addr after redirect", imem_req_addr, 32'h40);
    for (int i = 0; i < 3; i++) begin
      run(1'b0, 1'b0, 32'd0, 1'b1);
      check($sformatf("t3 id_valid quiet %0d", i), {31'b0, id_valid}, 32'd0);
    end
    repeat (8) run(1'b0, 1'b0, 32'd0, 1'b1);
    check_dq("t3 first delivery", 0, 32'h40);
    check_dq("t3 second delivery", 1, 32'h41);

    // Redirect coinciding with a response and a decode handshake.
    do_reset();
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    repeat (3) run(1'b0, 1'b0, 32'd0, 1'b1);
    run(1'b0, 1'b1, 32'h80, 1'b1);
    check("t4 id_valid at redirect", {31'b0, id_valid}, 32'd1);
    check("t4 id_pc at redirect", id_pc, 32'd0);
    check("t4 no req on redirect", {31'b0, imem_req_valid}, 32'd0);
    repeat (10) run(1'b0, 1'b0, 32'd0, 1'b1);
    check_dq("t4 delivery 0", 0, 32'd0);
    check_dq("t4 delivery 1", 1, 32'h80);
    check_dq("t4 delivery 2", 2, 32'h81);

    // Stall for five cycles with a redirect in the third.
    lat = 1;
    do_reset();
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    repeat (2) run(1'b0, 1'b0, 32'd0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      run(1'b1, (k == 2), 32'h40, 1'b1);
      check($sformatf("t5 stalled req %0d", k), {31'b0, imem_req_valid}, 32'd0);
    end
    run(1'b0, 1'b0, 32'd0, 1'b1);
    check("t5 req_valid after stall", {31'b0, imem_req_valid}, 32'd1);
    check("t5 req_addr after stall", imem_req_addr, 32'h40);
    repeat (5) run(1'b0, 1'b0, 32'd0, 1'b1);
    check_dq("t5 delivery 2", 2, 32'd2);
    check_dq("t5 delivery 3", 3, 32'h40);
    check_dq("t5 delivery 4", 4, 32'h41);

    // Reset asserted mid-burst.
    lat = 3;
    do_reset();
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    repeat (4) run(1'b0, 1'b0, 32'd0, 1'b1);
    check("t6 id_valid before reset", {31'b0, id_valid}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6 reset req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("t6 reset req_addr", imem_req_addr, 32'd0);
    check("t6 reset id_valid", {31'b0, id_valid}, 32'd0);
    check("t6 reset id_pc", id_pc, 32'd0);
    check("t6 reset id_inst", id_inst, 32'd0);
    do_reset();
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    check("t6 restart req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("t6 restart req_addr", imem_req_addr, 32'd0);
    repeat (8) run(1'b0, 1'b0, 32'd0, 1'b1);
    check_dq("t6 delivery 0", 0, 32'd0);
    check_dq("t6 delivery 1", 1, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
